// File: rtl/button_pkg.sv
// Shared channel state type, button bit indices and counter sizing for button_pulse_gen.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } chan_state_e;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;

  // One counter width shared by debounce and repeat timing: wide enough for the largest period.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, debounced level and one-cycle raw pulse.
// Auto-repeat while held is compiled in only when BUTTON_AUTOREPEAT_EN is defined.
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = 1_485_000,
  parameter int REPEAT_DELAY_CYC = 74_250_000,
  parameter int REPEAT_RATE_CYC  = 14_850_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_raw_i,
  output logic level_o,
  output logic raw_pulse_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_RATE_CYC);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q;
  logic          sync_q;
  chan_state_e   state_q, state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          rep_fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync_q  <= sync1_q;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY_CYC - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE_CYC - 1);

  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic [CW-1:0] rep_last;
  logic          rep_phase_q, rep_phase_d;

  assign rep_last = rep_phase_q ? RATE_LAST : DELAY_LAST;

  // Counts from the accepted press; a release bounce keeps counting but can only fire back in HELD.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_fire    = 1'b0;
    unique case (state_q)
      HELD: begin
        if (rep_cnt_q == rep_last) begin
          if (sync_q) begin
            rep_fire    = 1'b1;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b1;
          end
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
      RELEASE_DB: begin
        if (rep_cnt_q != rep_last) rep_cnt_d = rep_cnt_q + 1'b1;
      end
      default: begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    pulse_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!sync_q) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sync_q) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end else begin
          pulse_d = rep_fire;
        end
      end
      RELEASE_DB: begin
        if (sync_q) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level_o     = level_q;
  assign raw_pulse_o = pulse_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Four debounced button channels plus registered opposite-direction arbitration of the move pulses.
// Auto-repeat inside the channels is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_pulse_gen
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = 1_485_000,
  parameter int REPEAT_DELAY_CYC = 74_250_000,
  parameter int REPEAT_RATE_CYC  = 14_850_000
) (
  input  logic       clk_148Mhz,
  input  logic       reset_n,
  input  logic [3:0] btn_raw,
  output logic       buton_apasatL,
  output logic       buton_apasatR,
  output logic       buton_apasatU,
  output logic       buton_apasatD,
  output logic [3:0] btn_level
);

  logic [3:0] raw_pulse;
  logic [3:0] level;
  logic [3:0] pulse_q, pulse_d;

  for (genvar i = 0; i < 4; i++) begin : g_chan
    button_debounce_channel #(
      .DEBOUNCE_CYC    (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC (REPEAT_RATE_CYC)
    ) u_chan (
      .clk_i      (clk_148Mhz),
      .rst_ni     (reset_n),
      .btn_raw_i  (btn_raw[i]),
      .level_o    (level[i]),
      .raw_pulse_o(raw_pulse[i])
    );
  end

  // Simultaneous opposite requests cancel; masking by pulse_q guarantees a low cycle between pulses.
  always_comb begin
    pulse_d = raw_pulse;
    if (raw_pulse[BTN_L] && raw_pulse[BTN_R]) begin
      pulse_d[BTN_L] = 1'b0;
      pulse_d[BTN_R] = 1'b0;
    end
    if (raw_pulse[BTN_U] && raw_pulse[BTN_D]) begin
      pulse_d[BTN_U] = 1'b0;
      pulse_d[BTN_D] = 1'b0;
    end
    pulse_d = pulse_d & ~pulse_q;
  end

  always_ff @(posedge clk_148Mhz or negedge reset_n) begin
    if (!reset_n) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  assign buton_apasatL = pulse_q[BTN_L];
  assign buton_apasatR = pulse_q[BTN_R];
  assign buton_apasatU = pulse_q[BTN_U];
  assign buton_apasatD = pulse_q[BTN_D];
  assign btn_level     = level;

endmodule
